// File: rtl/axi_gp_pkg.sv
// Shared widths, response codes and FSM state types for the AXI GP register responder.
package axi_gp_pkg;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 12;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    W_ADDR = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;
endpackage

// File: rtl/axi_gp_if.sv
// AR/AW/W/R/B channel bundle. Handshake: a beat transfers in any cycle where ena and rdy are
// both high; the sender raises ena only while the receiver's rdy is high.
interface axi_gp_if;
  import axi_gp_pkg::*;

  logic              ar_ena;
  logic [ADDR_W-1:0] ar_addr;
  logic [ID_W-1:0]   ar_id;
  logic [LEN_W-1:0]  ar_len;
  logic              ar_rdy;

  logic              aw_ena;
  logic [ADDR_W-1:0] aw_addr;
  logic [ID_W-1:0]   aw_id;
  logic [LEN_W-1:0]  aw_len;
  logic              aw_rdy;

  logic              w_ena;
  logic [DATA_W-1:0] w_data;
  logic [ID_W-1:0]   w_id;
  logic              w_last;
  logic              w_rdy;

  logic              r_ena;
  logic [DATA_W-1:0] r_data;
  logic [ID_W-1:0]   r_id;
  logic              r_last;
  logic [1:0]        r_resp;
  logic              r_rdy;

  logic              b_ena;
  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;
  logic              b_rdy;

  modport slave (
    input  ar_ena, ar_addr, ar_id, ar_len, output ar_rdy,
    input  aw_ena, aw_addr, aw_id, aw_len, output aw_rdy,
    input  w_ena, w_data, w_id, w_last,    output w_rdy,
    output r_ena, r_data, r_id, r_last, r_resp, input r_rdy,
    output b_ena, b_id, b_resp,            input b_rdy
  );

  modport master (
    output ar_ena, ar_addr, ar_id, ar_len, input ar_rdy,
    output aw_ena, aw_addr, aw_id, aw_len, input aw_rdy,
    output w_ena, w_data, w_id, w_last,    input w_rdy,
    input  r_ena, r_data, r_id, r_last, r_resp, output r_rdy,
    input  b_ena, b_id, b_resp,            output b_rdy
  );
endinterface

// File: rtl/axi_gp_regbank.sv
// NREGS x 32-bit register array: one synchronous write port, one combinational read port.
module axi_gp_regbank
  import axi_gp_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int IDX_W = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] top_word_o
);
  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read sees the pre-edge value, so a same-cycle write is not forwarded.
  assign rdata_o    = regs_q[raddr_i];
  assign top_word_o = regs_q[NREGS-1];
endmodule

// File: rtl/axi_gp_responder.sv
// AXI GP slave exposing a small register bank; independent read and write FSMs.
module axi_gp_responder
  import axi_gp_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic       CLK,
  input  logic       nRST,
  axi_gp_if.slave    axi,
  output logic       interrupt,
  output rd_state_e  rd_state_o,
  output wr_state_e  wr_state_o
);
  localparam int IDX_W  = $clog2(NREGS);
  localparam int HI_LSB = IDX_W + 2;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;
  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  // Out of range means any nonzero bit between the word index and bit 11; bits above 11 are ignored.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    return a[11:HI_LSB] != '0;
  endfunction

  rd_state_e        rd_state_q, rd_state_d;
  logic [ID_W-1:0]  r_id_q, r_id_d;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic [LEN_W-1:0] r_rem_q, r_rem_d;
  logic             r_err_q, r_err_d;
  logic             ar_rdy, r_ena;

  wr_state_e        wr_state_q, wr_state_d;
  logic [ID_W-1:0]  w_id_q, w_id_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic             w_err_q, w_err_d;
  logic             w_mis_q, w_mis_d;
  logic             aw_rdy, w_rdy, b_ena, we;

  logic [DATA_W-1:0] rd_data, top_word;

  axi_gp_regbank #(.NREGS(NREGS), .IDX_W(IDX_W)) u_regbank (
    .clk_i      (CLK),
    .rst_ni     (nRST),
    .we_i       (we),
    .waddr_i    (w_idx_q),
    .wdata_i    (axi.w_data),
    .raddr_i    (r_idx_q),
    .rdata_o    (rd_data),
    .top_word_o (top_word)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_state_q <= R_IDLE;
      r_id_q     <= '0;
      r_idx_q    <= '0;
      r_rem_q    <= '0;
      r_err_q    <= 1'b0;
      wr_state_q <= W_ADDR;
      w_id_q     <= '0;
      w_idx_q    <= '0;
      w_err_q    <= 1'b0;
      w_mis_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      r_id_q     <= r_id_d;
      r_idx_q    <= r_idx_d;
      r_rem_q    <= r_rem_d;
      r_err_q    <= r_err_d;
      wr_state_q <= wr_state_d;
      w_id_q     <= w_id_d;
      w_idx_q    <= w_idx_d;
      w_err_q    <= w_err_d;
      w_mis_q    <= w_mis_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    r_id_d     = r_id_q;
    r_idx_d    = r_idx_q;
    r_rem_d    = r_rem_q;
    r_err_d    = r_err_q;
    ar_rdy     = 1'b0;
    r_ena      = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        ar_rdy = 1'b1;
        if (axi.ar_ena) begin
          r_id_d     = axi.ar_id;
          r_idx_d    = axi.ar_addr[IDX_W+1:2];
          r_rem_d    = axi.ar_len;
          r_err_d    = addr_err(axi.ar_addr);
          rd_state_d = R_BURST;
        end
      end
      R_BURST: begin
        r_ena = axi.r_rdy;
        if (axi.r_rdy) begin
          r_idx_d = r_idx_q + IDX_ONE;
          r_rem_d = r_rem_q - LEN_ONE;
          if (r_rem_q == '0) rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    w_id_d     = w_id_q;
    w_idx_d    = w_idx_q;
    w_err_d    = w_err_q;
    w_mis_d    = w_mis_q;
    aw_rdy     = 1'b0;
    w_rdy      = 1'b0;
    b_ena      = 1'b0;
    we         = 1'b0;
    case (wr_state_q)
      W_ADDR: begin
        aw_rdy = 1'b1;
        if (axi.aw_ena) begin
          w_id_d     = axi.aw_id;
          w_idx_d    = axi.aw_addr[IDX_W+1:2];
          w_err_d    = addr_err(axi.aw_addr);
          w_mis_d    = 1'b0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_rdy = 1'b1;
        if (axi.w_ena) begin
          // A mismatched W id still writes; it only poisons the B response.
          we      = !w_err_q;
          w_idx_d = w_idx_q + IDX_ONE;
          if (axi.w_id != w_id_q) w_mis_d = 1'b1;
          if (axi.w_last) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_ena = axi.b_rdy;
        if (axi.b_rdy) wr_state_d = W_ADDR;
      end
      default: wr_state_d = W_ADDR;
    endcase
  end

  assign axi.ar_rdy = ar_rdy;
  assign axi.r_ena  = r_ena;
  assign axi.r_data = r_err_q ? '0 : rd_data;
  assign axi.r_id   = r_id_q;
  assign axi.r_resp = r_err_q ? RESP_SLVERR : RESP_OKAY;
  assign axi.r_last = (r_rem_q == '0);

  assign axi.aw_rdy = aw_rdy;
  assign axi.w_rdy  = w_rdy;
  assign axi.b_ena  = b_ena;
  assign axi.b_id   = w_id_q;
  assign axi.b_resp = (w_err_q || w_mis_q) ? RESP_SLVERR : RESP_OKAY;

  assign interrupt  = |top_word;
  assign rd_state_o = rd_state_q;
  assign wr_state_o = wr_state_q;

  // Burst length on AW and the address bits outside the decode window carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{axi.aw_len, axi.ar_addr[ADDR_W-1:12], axi.ar_addr[1:0],
                         axi.aw_addr[ADDR_W-1:12], axi.aw_addr[1:0]};
endmodule

// File: tb/tb_axi_gp_responder.sv
// Directed and randomized checks of axi_gp_responder against an array-based register model.
module tb_axi_gp_responder;
  import axi_gp_pkg::*;

  logic      clk = 1'b0;
  logic      nrst = 1'b0;
  logic      irq;
  rd_state_e rd_state;
  wr_state_e wr_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] mregs [16];
  logic [31:0] exp_q [$];

  axi_gp_if axi();

  axi_gp_responder #(.NREGS(16)) dut (
    .CLK        (clk),
    .nRST       (nrst),
    .axi        (axi),
    .interrupt  (irq),
    .rd_state_o (rd_state),
    .wr_state_o (wr_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit out_of_range(input logic [31:0] addr);
    return ((addr >> 6) & 32'h3f) != 0;
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) & 32'hf);
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [11:0] id, input logic [11:0] wid,
                           input logic [31:0] data [$]);
    int  to;
    int  nb;
    bit  err;
    int  idx;
    nb  = data.size();
    err = out_of_range(addr);
    idx = word_of(addr);
    @(negedge clk);
    to = 0;
    while (!axi.aw_rdy && to < 20) begin @(negedge clk); to++; end
    check("aw_rdy", 32'(axi.aw_rdy), 32'd1);
    axi.aw_ena = 1'b1; axi.aw_addr = addr; axi.aw_id = id; axi.aw_len = 4'(nb - 1);
    @(posedge clk); #1 axi.aw_ena = 1'b0;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      to = 0;
      while (!axi.w_rdy && to < 20) begin @(negedge clk); to++; end
      check("w_rdy", 32'(axi.w_rdy), 32'd1);
      axi.w_ena = 1'b1; axi.w_data = data[b]; axi.w_id = wid; axi.w_last = (b == nb - 1);
      @(posedge clk);
      if (!err) mregs[(idx + b) % 16] = data[b];
      #1 axi.w_ena = 1'b0; axi.w_last = 1'b0;
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(negedge clk);
    axi.b_rdy = 1'b1;
    #1;
    check("b_ena", 32'(axi.b_ena), 32'd1);
    check("b_id", 32'(axi.b_id), 32'(id));
    check("b_resp", 32'(axi.b_resp), (err || wid != id) ? 32'd2 : 32'd0);
    @(posedge clk); #1 axi.b_rdy = 1'b0;
    check("irq", 32'(irq), 32'(mregs[15] != 0));
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [11:0] id, input int nb,
                          input int stall_beat, input int stall_cycles, input bit rand_bp);
    int to;
    int k;
    int stalled;
    bit err;
    bit rdy;
    err = out_of_range(addr);
    for (int i = 0; i < nb; i++) exp_q.push_back(err ? 32'd0 : mregs[(word_of(addr) + i) % 16]);
    @(negedge clk);
    to = 0;
    while (!axi.ar_rdy && to < 20) begin @(negedge clk); to++; end
    check("ar_rdy", 32'(axi.ar_rdy), 32'd1);
    axi.ar_ena = 1'b1; axi.ar_addr = addr; axi.ar_id = id; axi.ar_len = 4'(nb - 1);
    @(posedge clk); #1 axi.ar_ena = 1'b0;
    k = 0; to = 0; stalled = 0;
    while (k < nb && to < 200) begin
      @(negedge clk);
      to++;
      if (k == stall_beat && stalled < stall_cycles) begin rdy = 1'b0; stalled++; end
      else if (rand_bp) rdy = ($urandom_range(0, 3) != 0);
      else rdy = 1'b1;
      axi.r_rdy = rdy;
      #1;
      check("ar_rdy_busy", 32'(axi.ar_rdy), 32'd0);
      if (rdy) begin
        check("r_ena", 32'(axi.r_ena), 32'd1);
        check("r_data", axi.r_data, exp_q.pop_front());
        check("r_id", 32'(axi.r_id), 32'(id));
        check("r_resp", 32'(axi.r_resp), err ? 32'd2 : 32'd0);
        check("r_last", 32'(axi.r_last), 32'(k == nb - 1));
        k++;
      end else begin
        check("r_ena_stall", 32'(axi.r_ena), 32'd0);
      end
    end
    check("r_burst_done", 32'(k), 32'(nb));
    @(posedge clk); #1 axi.r_rdy = 1'b0;
    @(negedge clk);
    check("ar_rdy_after", 32'(axi.ar_rdy), 32'd1);
  endtask

  initial begin : main
    logic [31:0] dq [$];
    logic [31:0] a, old_v, new_v;
    logic [11:0] id;
    int          nb;

    for (int i = 0; i < 16; i++) mregs[i] = '0;
    axi.ar_ena = 0; axi.ar_addr = 0; axi.ar_id = 0; axi.ar_len = 0;
    axi.aw_ena = 0; axi.aw_addr = 0; axi.aw_id = 0; axi.aw_len = 0;
    axi.w_ena = 0; axi.w_data = 0; axi.w_id = 0; axi.w_last = 0;
    axi.r_rdy = 0; axi.b_rdy = 0;

    // Reset state with both response-side ready inputs high.
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    axi.r_rdy = 1'b1; axi.b_rdy = 1'b1;
    #1;
    check("rst_ar_rdy", 32'(axi.ar_rdy), 32'd1);
    check("rst_aw_rdy", 32'(axi.aw_rdy), 32'd1);
    check("rst_w_rdy", 32'(axi.w_rdy), 32'd0);
    check("rst_r_ena", 32'(axi.r_ena), 32'd0);
    check("rst_b_ena", 32'(axi.b_ena), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rd_state", 32'(rd_state), 32'(R_IDLE));
    check("rst_wr_state", 32'(wr_state), 32'(W_ADDR));
    axi.r_rdy = 1'b0; axi.b_rdy = 1'b0;

    // Single-beat write then read back.
    dq = '{32'hDEADBEEF};
    axi_write(32'h08, 12'd5, 12'd5, dq);
    axi_read(32'h08, 12'd3, 1, -1, 0, 1'b0);

    // Burst into regs 14,15 then a wrapping read 15,0,1.
    dq = '{32'h1111_0E0E, 32'h8000_0001};
    axi_write(32'h38, 12'd2, 12'd2, dq);
    check("irq_reg15", 32'(irq), 32'd1);
    axi_read(32'h3C, 12'd6, 3, -1, 0, 1'b0);

    // Out-of-range read and write.
    axi_read(32'h100, 12'd9, 2, -1, 0, 1'b0);
    dq = '{32'hCAFE_F00D};
    axi_write(32'h100, 12'd4, 12'd4, dq);
    axi_read(32'h0, 12'd1, 16, -1, 0, 1'b0);

    // W id mismatch still writes but reports SLVERR.
    dq = '{32'h0BAD_1D00};
    axi_write(32'h10, 12'd5, 12'd7, dq);
    axi_read(32'h10, 12'd2, 1, -1, 0, 1'b0);

    // Three-cycle stall in the middle of a burst.
    axi_read(32'h34, 12'd8, 4, 1, 3, 1'b0);

    // Same-cycle write and read of one register: the read returns the old value.
    old_v = mregs[3];
    new_v = $urandom;
    @(negedge clk);
    axi.ar_ena = 1'b1; axi.ar_addr = 32'h0C; axi.ar_id = 12'd9; axi.ar_len = 4'd0;
    axi.aw_ena = 1'b1; axi.aw_addr = 32'h0C; axi.aw_id = 12'd4; axi.aw_len = 4'd0;
    @(posedge clk); #1 axi.ar_ena = 1'b0; axi.aw_ena = 1'b0;
    @(negedge clk);
    axi.w_ena = 1'b1; axi.w_data = new_v; axi.w_id = 12'd4; axi.w_last = 1'b1;
    axi.r_rdy = 1'b1;
    #1;
    check("coll_r_ena", 32'(axi.r_ena), 32'd1);
    check("coll_r_old", axi.r_data, old_v);
    @(posedge clk);
    mregs[3] = new_v;
    #1 axi.w_ena = 1'b0; axi.w_last = 1'b0; axi.r_rdy = 1'b0;
    @(negedge clk);
    axi.b_rdy = 1'b1;
    #1;
    check("coll_b_ena", 32'(axi.b_ena), 32'd1);
    check("coll_b_resp", 32'(axi.b_resp), 32'd0);
    @(posedge clk); #1 axi.b_rdy = 1'b0;
    axi_read(32'h0C, 12'd9, 1, -1, 0, 1'b0);

    // Randomized traffic, including ignored upper address bits and errors.
    for (int it = 0; it < 12; it++) begin
      nb = $urandom_range(1, 4);
      a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 5) == 0) a = a | (32'h1 << $urandom_range(6, 11));
      id = 12'($urandom);
      dq.delete();
      for (int b = 0; b < nb; b++) dq.push_back($urandom);
      axi_write(a, id, ($urandom_range(0, 5) == 0) ? ~id : id, dq);
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 5) == 0) a = a | (32'h1 << $urandom_range(6, 11));
      axi_read(a, 12'($urandom), $urandom_range(1, 16), -1, 0, 1'b1);
    end

    // Reset on beat 2 of a 4-beat burst.
    @(negedge clk);
    axi.ar_ena = 1'b1; axi.ar_addr = 32'h0; axi.ar_id = 12'd1; axi.ar_len = 4'd3;
    @(posedge clk); #1 axi.ar_ena = 1'b0;
    @(negedge clk);
    axi.r_rdy = 1'b1;
    #1;
    check("rb_beat1", axi.r_data, mregs[0]);
    @(posedge clk); #1 axi.r_rdy = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    #1 nrst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      axi.r_rdy = 1'b1;
      #1;
      check("rb_r_ena", 32'(axi.r_ena), 32'd0);
      check("rb_ar_rdy", 32'(axi.ar_rdy), 32'd1);
      check("rb_irq", 32'(irq), 32'd0);
    end
    axi.r_rdy = 1'b0;
    axi_read(32'h0, 12'd2, 16, -1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
